// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The ROM window is [RESET_PC, ROM_LAST]; anything outside it is a fetch fault.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int ROM_BYTES   = 4096;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] ROM_LAST = RESET_PC + XLEN'(ROM_BYTES - INSTR_BYTES);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic in_rom_range(input logic [XLEN-1:0] addr);
    return (addr >= RESET_PC) && (addr <= ROM_LAST);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} pairs between the fetch PC and decode.
// The head is read straight from storage, so a pushed entry is visible one edge later.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);

  // A flush cancels both sides of the handshake in that cycle.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= entry_i;
  end

  assign head_o = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the fetch PC, reads the ROM combinationally and buffers
// {pc, instr} pairs for decode. Redirects flush the buffer; bad PCs raise a sticky fault.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  output logic            fault_o
);

  logic [XLEN-1:0] fetch_pc;
  logic            fault_q;
  logic            pc_bad;
  logic            pop;
  logic            push;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    head;
  fetch_entry_t    entry_in;

  assign pc_bad = (fetch_pc[1:0] != 2'b00) || !in_rom_range(fetch_pc);

  // Redirect wins: a head shown in the redirect cycle is never consumed.
  assign pop  = instr_valid_o & instr_ready_i & ~redirect_i;
  assign push = ~redirect_i & ~fault_q & ~pc_bad & (~fifo_full | pop);

  assign entry_in = '{pc: fetch_pc, instr: imem_rdata_i};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (redirect_i),
    .push_i  (push),
    .entry_i (entry_in),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Once faulted the PC is frozen; only reset recovers, redirects just flush.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      fetch_pc <= RESET_PC;
      fault_q  <= 1'b0;
    end else if (redirect_i) begin
      if (!fault_q) fetch_pc <= redirect_pc_i;
    end else begin
      if (push)   fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
      if (pc_bad) fault_q  <= 1'b1;
    end
  end

  assign imem_addr_o   = fetch_pc;
  assign fault_o       = fault_q;
  assign instr_valid_o = ~fifo_empty;
  assign instr_o       = fifo_empty ? '0 : head.instr;
  assign instr_pc_o    = fifo_empty ? '0 : head.pc;

endmodule
